// File: rtl/cu_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit: control-word
// field positions, control states, PC function encodings and the fetch word.
package cu_pkg;

   localparam int CW_W = 33;

   // Control-word field bit positions
   localparam int CW_ALU_EN      = 32;
   localparam int CW_B_SEL       = 31;
   localparam int CW_FS_HI       = 30;
   localparam int CW_FS_LO       = 26;
   localparam int CW_RFB_EN      = 25;
   localparam int CW_SA_HI       = 24;
   localparam int CW_SA_LO       = 20;
   localparam int CW_SB_HI       = 19;
   localparam int CW_SB_LO       = 15;
   localparam int CW_DA_HI       = 14;
   localparam int CW_DA_LO       = 10;
   localparam int CW_RF_WRITE    = 9;
   localparam int CW_RAM_EN      = 8;
   localparam int CW_RAM_WRITE   = 7;
   localparam int CW_PC_EN       = 6;
   localparam int CW_PC_FS_HI    = 5;
   localparam int CW_PC_FS_LO    = 4;
   localparam int CW_PC_SEL      = 3;
   localparam int CW_STATUS_LOAD = 2;
   localparam int CW_NS_HI       = 1;
   localparam int CW_NS_LO       = 0;

   // PC function select encodings
   localparam logic [1:0] PC_FS_HOLD = 2'b00;
   localparam logic [1:0] PC_FS_INC  = 2'b01;

   typedef enum logic [1:0] {
      STATE_FETCH = 2'd0,
      STATE_EX1   = 2'd1,
      STATE_EX2   = 2'd2,
      STATE_EX3   = 2'd3
   } state_t;

   // Fetch: read RAM at PC, advance PC by 4, go to state 1.
   localparam logic [CW_W-1:0] FETCH_CW = 33'h0_0000_0111;

   // Replace the PC_FS field of a control word.
   function automatic logic [CW_W-1:0] set_pc_fs(input logic [CW_W-1:0] cw_in,
                                                  input logic [1:0]      fs);
      logic [CW_W-1:0] r;
      r = cw_in;
      r[CW_PC_FS_HI:CW_PC_FS_LO] = fs;
      return r;
   endfunction

endpackage

// File: rtl/cu_stall_gate.sv
// Masks the decoded control word while a RAM access is outstanding: nothing
// that commits architectural state may fire, but the RAM request stays up.
module cu_stall_gate
   import cu_pkg::*;
(
   input  logic [CW_W-1:0] cw_dec,
   input  logic            stall,
   output logic [CW_W-1:0] cw_out
);

   // Suppress register-file write, flag load and PC update during a stall
   always_comb begin
      // NOTE: assign the output unconditionally first so no path leaves it unassigned (no latch).
      cw_out = cw_dec;
      if (stall) begin
         cw_out[CW_RF_WRITE]    = 1'b0;
         cw_out[CW_STATUS_LOAD] = 1'b0;
         cw_out                 = set_pc_fs(cw_out, PC_FS_HOLD);
      end
   end

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle LEGv8 control sequencer: owns the instruction register and the
// control state, emits the fetch word in state 0 and the (stall-gated)
// decoder word in states 1-3, supports halt-at-boundary and counts retirements.
module cu_sequencer
   import cu_pkg::*;
#(
   parameter int         CNT_W       = 16,
   parameter logic [1:0] FETCH_PC_FS = 2'b01
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      instr_in,
   input  logic [CW_W-1:0]  cw_dec,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic [31:0]      I,
   output logic [1:0]       state,
   output logic [CW_W-1:0]  cw,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [CW_W-1:0] FETCH_WORD = set_pc_fs(FETCH_CW, FETCH_PC_FS);

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall;
   logic [CW_W-1:0]  cw_gated;

   assign stall = cw_dec[CW_RAM_EN] & ~mem_ready;

   cu_stall_gate u_stall_gate (
      .cw_dec (cw_dec),
      .stall  (stall),
      .cw_out (cw_gated)
   );

   // Next-state, IR/counter/halt updates and control-word output
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      cw       = '0;

      if (state_q == STATE_FETCH) begin
         if (halted_q) begin
            // Idle until halt_req drops; the fetch begins the following cycle.
            halted_d = halt_req;
         end else begin
            // A fetch once started runs to completion; halt_req is ignored here.
            cw = FETCH_WORD;
            if (mem_ready) begin
               ir_d    = instr_in;
               state_d = STATE_EX1;
            end else begin
               cw = set_pc_fs(cw, PC_FS_HOLD);
            end
         end
      end else begin
         cw = cw_gated;
         if (!stall) begin
            state_d = state_t'(cw_dec[CW_NS_HI:CW_NS_LO]);
            if (cw_dec[CW_NS_HI:CW_NS_LO] == STATE_FETCH) begin
               cnt_d    = cnt_q + CNT_W'(1);
               halted_d = halt_req;
            end
         end
      end

      // Reset kills any in-flight write by zeroing the control word.
      if (!reset) cw = '0;
   end

   // State, IR, halt flag and retirement counter registers
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments; reset is sampled synchronously.
      if (!reset) begin
         state_q  <= STATE_FETCH;
         ir_q     <= '0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign I           = ir_q;
   assign state       = state_q;
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed self-checking bench for cu_sequencer (counter width 4 so the
// wrap-around is reachable in a few dozen cycles).
module tb_cu_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instr_in;
   logic [32:0] cw_dec;
   logic        mem_ready;
   logic        halt_req;
   logic [31:0] I;
   logic [1:0]  state;
   logic [32:0] cw;
   logic        halted;
   logic [3:0]  instr_count;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [32:0] FETCH_W    = 33'h0_0000_0111;  // RAM_EN, PC_FS=01, NS=1
   localparam logic [32:0] FETCH_STL  = 33'h0_0000_0101;  // same with PC_FS=00

   cu_sequencer #(.CNT_W(4), .FETCH_PC_FS(2'b01)) dut (
      .clock       (clock),
      .reset       (reset),
      .instr_in    (instr_in),
      .cw_dec      (cw_dec),
      .mem_ready   (mem_ready),
      .halt_req    (halt_req),
      .I           (I),
      .state       (state),
      .cw          (cw),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      instr_in  = '0;
      cw_dec    = '0;
      mem_ready = 1'b1;
      halt_req  = 1'b0;
      #1;
      check("cw_in_reset", cw, 33'h0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("rst_state", state, 2'd0);
      check("rst_I", I, 32'h0);
      check("rst_count", instr_count, 4'd0);
      check("rst_halted", halted, 1'b0);
      check("rst_cw_fetch", cw, FETCH_W);

      // Fetch then a single-cycle instruction (ALU_EN + RF_WRITE, NS=0)
      instr_in = 32'hF280_0041;
      cw_dec   = 33'h1_0000_0200;
      tick();
      check("sc_I", I, 32'hF280_0041);
      check("sc_state1", state, 2'd1);
      check("sc_cw_dec", cw, 33'h1_0000_0200);
      check("sc_count_pre", instr_count, 4'd0);
      tick();
      check("sc_state0", state, 2'd0);
      check("sc_count", instr_count, 4'd1);
      check("sc_cw_fetch", cw, FETCH_W);

      // Multi-cycle: 0 -> 1 -> 2 -> 3 -> 0
      cw_dec = 33'h0_0000_0202;
      tick();
      check("mc_s1", state, 2'd1);
      tick();
      check("mc_s2", state, 2'd2);
      cw_dec = 33'h0_0000_0203;
      tick();
      check("mc_s3", state, 2'd3);
      check("mc_count_mid", instr_count, 4'd1);
      cw_dec = 33'h0_0000_0200;
      tick();
      check("mc_s0", state, 2'd0);
      check("mc_count", instr_count, 4'd2);

      // RAM stall in state 2: RF_WRITE|RAM_EN|RAM_WRITE|PC_FS=01|STATUS|NS=3
      cw_dec = 33'h0_0000_0002;
      tick();
      tick();
      check("st_s2", state, 2'd2);
      cw_dec    = 33'h0_0000_0397;
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("st_cw_gated", cw, 33'h0_0000_0183);
         tick();
         check("st_hold", state, 2'd2);
      end
      mem_ready = 1'b1;
      #1;
      check("st_cw_ungated", cw, 33'h0_0000_0397);
      tick();
      check("st_adv", state, 2'd3);
      cw_dec = 33'h0_0000_0000;
      tick();
      check("st_ret", instr_count, 4'd3);

      // Fetch stalled by RAM: PC must not advance, state holds
      mem_ready = 1'b0;
      #1;
      check("fs_cw", cw, FETCH_STL);
      tick();
      check("fs_hold", state, 2'd0);
      mem_ready = 1'b1;

      // Halt requested in state 1 of a 2-cycle instruction
      cw_dec = 33'h0_0000_0002;
      tick();
      check("h_s1", state, 2'd1);
      halt_req = 1'b1;
      tick();
      check("h_s2", state, 2'd2);
      check("h_mid_nohalt", halted, 1'b0);
      cw_dec = 33'h0_0000_0000;
      tick();
      check("h_s0", state, 2'd0);
      check("h_count", instr_count, 4'd4);
      check("h_halted", halted, 1'b1);
      check("h_cw_idle", cw, 33'h0);
      tick();
      check("h_stay", halted, 1'b1);
      check("h_stay_state", state, 2'd0);
      halt_req = 1'b0;
      #1;
      check("h_cw_still_idle", cw, 33'h0);
      tick();
      check("h_release", halted, 1'b0);
      check("h_cw_fetch", cw, FETCH_W);

      // Counter wrap at 16 retirements (12 more single-cycle instructions)
      cw_dec = 33'h0_0000_0000;
      for (int i = 0; i < 12; i++) begin
         tick();
         tick();
         if (i == 10) check("wrap_15", instr_count, 4'd15);
      end
      check("wrap_0", instr_count, 4'd0);

      // Reset while in state 3
      cw_dec = 33'h0_0000_0202;
      tick();
      tick();
      cw_dec = 33'h0_0000_0203;
      tick();
      check("mr_s3", state, 2'd3);
      reset = 1'b0;
      #1;
      check("mr_cw_zero", cw, 33'h0);
      tick();
      check("mr_state", state, 2'd0);
      check("mr_I", I, 32'h0);
      check("mr_count", instr_count, 4'd0);
      reset = 1'b1;
      #1;
      check("mr_cw_fetch", cw, FETCH_W);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
